// File: rtl/axi4_slave_write_ctrl_pkg.sv
// Shared AXI4 write-path types: burst/response codes, the queued AW entry
// and the default 12 KB decode window.
package axi4_slave_write_ctrl_pkg;

    localparam int unsigned AXI4_ID_WIDTH   = 4;
    localparam int unsigned AXI4_ADDR_WIDTH = 32;

    localparam logic [AXI4_ADDR_WIDTH-1:0] AXI4_WIN_MIN_ADDR = 32'h0000_0000;
    localparam logic [AXI4_ADDR_WIDTH-1:0] AXI4_WIN_MAX_ADDR = 32'h0000_2FFF;

    typedef enum logic [1:0] {
        BURST_FIXED    = 2'b00,
        BURST_INCR     = 2'b01,
        BURST_WRAP     = 2'b10,
        BURST_RESERVED = 2'b11
    } axi4_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi4_resp_e;

    typedef struct packed {
        logic [AXI4_ID_WIDTH-1:0]   id;
        logic [AXI4_ADDR_WIDTH-1:0] addr;
        logic [7:0]                 len;
        logic [2:0]                 size;
        axi4_burst_e                burst;
    } axi4_aw_entry_s;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } wr_state_e;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_sync_fifo.sv
// Synchronous FIFO for queued write-address entries; DEPTH must be a power of 2
// so the read/write pointers wrap naturally.
module axi4_sync_fifo
    import axi4_slave_write_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(axi4_aw_entry_s),
    parameter int unsigned DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CNT_WIDTH'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            count <= count + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);
        end
    end

endmodule

// File: rtl/axi4_slave_write_ctrl.sv
// AXI4 slave write-path controller: queues AW requests, walks FIXED/INCR/WRAP
// beat addresses onto a byte-strobed memory port and returns in-order B responses.
module axi4_slave_write_ctrl
    import axi4_slave_write_ctrl_pkg::*;
#(
    parameter int unsigned                ADDRESS_WIDTH     = AXI4_ADDR_WIDTH,
    parameter int unsigned                DATA_WIDTH        = 64,
    parameter int unsigned                ID_WIDTH          = AXI4_ID_WIDTH,
    parameter int unsigned                OUTSTANDING_DEPTH = 16,
    parameter logic [ADDRESS_WIDTH-1:0]   MIN_ADDRESS       = AXI4_WIN_MIN_ADDR,
    parameter logic [ADDRESS_WIDTH-1:0]   MAX_ADDRESS       = AXI4_WIN_MAX_ADDR
) (
    input  logic                                       aclk,
    input  logic                                       aresetn,
    input  logic [ID_WIDTH-1:0]                        awid,
    input  logic [ADDRESS_WIDTH-1:0]                   awaddr,
    input  logic [7:0]                                 awlen,
    input  logic [2:0]                                 awsize,
    input  logic [1:0]                                 awburst,
    input  logic                                       awvalid,
    output logic                                       awready,
    input  logic [DATA_WIDTH-1:0]                      wdata,
    input  logic [DATA_WIDTH/8-1:0]                    wstrb,
    input  logic                                       wlast,
    input  logic                                       wvalid,
    output logic                                       wready,
    output logic [ID_WIDTH-1:0]                        bid,
    output logic [1:0]                                 bresp,
    output logic                                       bvalid,
    input  logic                                       bready,
    output logic                                       mem_we,
    output logic [ADDRESS_WIDTH-1:0]                   mem_addr,
    output logic [DATA_WIDTH-1:0]                      mem_wdata,
    output logic [DATA_WIDTH/8-1:0]                    mem_wstrb,
    output logic [$clog2(OUTSTANDING_DEPTH+1)-1:0]     outstanding_count
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = $clog2(OUTSTANDING_DEPTH + 1);
    localparam int unsigned MAX_SIZE   = $clog2(STRB_WIDTH);

    wr_state_e                state_q, state_d;
    axi4_aw_entry_s           push_entry;
    axi4_aw_entry_s           head;
    logic                     push;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CNT_WIDTH-1:0]     count;
    logic [CNT_WIDTH-1:0]     count_next;
    logic                     awready_q;

    logic [ID_WIDTH-1:0]      id_q, id_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]               len_q, len_d;
    logic [7:0]               beat_q, beat_d;
    logic [2:0]               size_q, size_d;
    axi4_burst_e              burst_q, burst_d;
    axi4_resp_e               err_q, err_d;

    logic [ADDRESS_WIDTH-1:0] head_addr;
    logic [ADDRESS_WIDTH-1:0] head_mask;
    logic [ADDRESS_WIDTH:0]   below_diff;
    logic [ADDRESS_WIDTH:0]   above_diff;
    axi4_resp_e               head_err;
    logic [ADDRESS_WIDTH-1:0] step;
    logic [ADDRESS_WIDTH-1:0] wrap_mask;
    logic [ADDRESS_WIDTH-1:0] next_addr;

    assign push              = awvalid && awready_q && !fifo_full;
    assign awready           = awready_q;
    assign outstanding_count = count;

    always_comb begin
        push_entry       = '0;
        push_entry.id    = AXI4_ID_WIDTH'(awid);
        push_entry.addr  = AXI4_ADDR_WIDTH'(awaddr);
        push_entry.len   = awlen;
        push_entry.size  = awsize;
        push_entry.burst = axi4_burst_e'(awburst);
    end

    axi4_sync_fifo #(
        .WIDTH ($bits(axi4_aw_entry_s)),
        .DEPTH (OUTSTANDING_DEPTH)
    ) u_aw_fifo (
        .clk       (aclk),
        .rst_n     (aresetn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    // awready is registered, so it must look at the occupancy the FIFO will have next cycle
    assign count_next = count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awready_q <= 1'b0;
        end else begin
            awready_q <= (count_next != CNT_WIDTH'(OUTSTANDING_DEPTH));
        end
    end

    // Start-address decode uses the borrow of a widened subtraction for the window bounds
    always_comb begin
        head_addr  = ADDRESS_WIDTH'(head.addr);
        head_mask  = (ADDRESS_WIDTH'(1) << head.size) - ADDRESS_WIDTH'(1);
        below_diff = {1'b0, head_addr} - {1'b0, MIN_ADDRESS};
        above_diff = {1'b0, MAX_ADDRESS} - {1'b0, head_addr};
        head_err   = RESP_OKAY;
        if (below_diff[ADDRESS_WIDTH] || above_diff[ADDRESS_WIDTH]) begin
            head_err = RESP_DECERR;
        end else if ((head.burst == BURST_RESERVED) ||
                     ((head.burst == BURST_WRAP) && !wrap_len_ok(head.len)) ||
                     ((head.burst == BURST_WRAP) && ((head_addr & head_mask) != '0)) ||
                     (32'(head.size) > MAX_SIZE)) begin
            head_err = RESP_SLVERR;
        end
    end

    always_comb begin
        step      = ADDRESS_WIDTH'(1) << size_q;
        wrap_mask = (ADDRESS_WIDTH'({1'b0, len_q} + 9'd1) << size_q) - ADDRESS_WIDTH'(1);
        case (burst_q)
            BURST_FIXED: next_addr = addr_q;
            BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) + ((addr_q + step) & wrap_mask);
            default:     next_addr = addr_q + step;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            size_q  <= '0;
            burst_q <= BURST_FIXED;
            err_q   <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        size_d    = size_q;
        burst_d   = burst_q;
        err_d     = err_q;
        pop       = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bid       = '0;
        bresp     = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    id_d    = ID_WIDTH'(head.id);
                    addr_d  = head_addr & ~head_mask;
                    len_d   = head.len;
                    size_d  = head.size;
                    burst_d = head.burst;
                    err_d   = head_err;
                    beat_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    mem_we    = (err_q == RESP_OKAY);
                    mem_addr  = addr_q;
                    mem_wdata = wdata;
                    mem_wstrb = wstrb;
                    addr_d    = next_addr;
                    beat_d    = beat_q + 8'd1;
                    // A misplaced wlast poisons only the following beats; the burst length still follows awlen
                    if ((wlast != (beat_q == len_q)) && (err_q != RESP_DECERR)) begin
                        err_d = RESP_SLVERR;
                    end
                    if (beat_q == len_q) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                bvalid = 1'b1;
                bid    = id_q;
                bresp  = err_q;
                if (bready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_slave_write_ctrl.sv
// Scoreboard bench for axi4_slave_write_ctrl: directed scenarios plus random bursts
// checked against a formula-level model of beat addresses and response codes.
module tb_axi4_slave_write_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic [4:0]  outstanding_count;

    axi4_slave_write_ctrl dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .awid              (awid),
        .awaddr            (awaddr),
        .awlen             (awlen),
        .awsize            (awsize),
        .awburst           (awburst),
        .awvalid           (awvalid),
        .awready           (awready),
        .wdata             (wdata),
        .wstrb             (wstrb),
        .wlast             (wlast),
        .wvalid            (wvalid),
        .wready            (wready),
        .bid               (bid),
        .bresp             (bresp),
        .bvalid            (bvalid),
        .bready            (bready),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_wstrb         (mem_wstrb),
        .outstanding_count (outstanding_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } aw_t;
    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } wr_t;
    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    int   checks = 0;
    int   errors = 0;
    aw_t  pend[$];
    wr_t  exp_w[$];
    b_t   exp_b[$];
    logic [7:0] strb_plan[$];
    int   acc_count = 0;
    int   prev_count = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endfunction

    // Reference model: response from the start-address window and burst legality rules
    function automatic logic [1:0] model_base(input aw_t a);
        longint unsigned step;
        step = 64'd1 << a.size;
        if (a.addr > 32'h0000_2FFF) return 2'b11;
        if (a.burst == 2'b11) return 2'b10;
        if (step > 64'd8) return 2'b10;
        if (a.burst == 2'b10 && !(a.len == 8'd1 || a.len == 8'd3 || a.len == 8'd7 || a.len == 8'd15)) return 2'b10;
        if (a.burst == 2'b10 && (longint'(a.addr) % step) != 0) return 2'b10;
        return 2'b00;
    endfunction

    // Reference model: byte address of beat i
    function automatic logic [31:0] model_addr(input aw_t a, input int i);
        longint unsigned step, start, total, lower, res;
        step  = 64'd1 << a.size;
        start = longint'(a.addr) - (longint'(a.addr) % step);
        total = (longint'(a.len) + 1) * step;
        case (a.burst)
            2'b00:   res = start;
            2'b10: begin
                lower = (start / total) * total;
                res   = lower + ((start - lower + longint'(i) * step) % total);
            end
            default: res = (start + longint'(i) * step) % (64'd1 << 32);
        endcase
        return res[31:0];
    endfunction

    always @(negedge aclk) begin
        wr_t e;
        b_t  eb;
        if (aresetn && mem_we) begin
            if (exp_w.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h required=no write", mem_addr);
            end else begin
                e = exp_w.pop_front();
                chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                chk("mem_wdata", mem_wdata, e.data);
                chk("mem_wstrb", 64'(mem_wstrb), 64'(e.strb));
            end
        end
        if (aresetn && bvalid && bready) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_b actual=%0h required=no response", bid);
            end else begin
                eb = exp_b.pop_front();
                chk("bid", 64'(bid), 64'(eb.id));
                chk("bresp", 64'(bresp), 64'(eb.resp));
            end
        end
    end

    task automatic send_aw(input aw_t a);
        int n = 0;
        awid = a.id; awaddr = a.addr; awlen = a.len; awsize = a.size; awburst = a.burst;
        awvalid = 1'b1;
        prev_count = int'(outstanding_count);
        forever begin
            @(negedge aclk);
            if (awready) begin
                acc_count = int'(outstanding_count);
                break;
            end
            prev_count = int'(outstanding_count);
            n++;
            if (n > 500) begin
                fail_evt("aw_timeout");
                break;
            end
        end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        pend.push_back(a);
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
        int n = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (wready) break;
            n++;
            if (n > 500) begin
                fail_evt("w_timeout");
                break;
            end
        end
        @(posedge aclk); #1;
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic send_w(input int bad_last);
        aw_t         a;
        logic [1:0]  base;
        bit          viol = 0;
        logic [63:0] d;
        logic [7:0]  s;
        logic        l;
        int          n = 0;
        while (pend.size() == 0) begin
            @(posedge aclk); #1;
            n++;
            if (n > 500) begin
                fail_evt("pend_timeout");
                return;
            end
        end
        a    = pend.pop_front();
        base = model_base(a);
        for (int i = 0; i <= int'(a.len); i++) begin
            d = {$urandom, $urandom};
            s = (strb_plan.size() != 0) ? strb_plan.pop_front() : 8'($urandom);
            l = (bad_last >= 0) ? (i == bad_last) : (i == int'(a.len));
            if (base == 2'b00 && !viol) exp_w.push_back('{model_addr(a, i), d, s});
            if (l != (i == int'(a.len))) viol = 1;
            drive_beat(d, s, l);
        end
        exp_b.push_back('{a.id, (base == 2'b11) ? 2'b11 : ((base == 2'b10 || viol) ? 2'b10 : 2'b00)});
    endtask

    task automatic run(input aw_t a, input int bad_last);
        send_aw(a);
        send_w(bad_last);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_b.size() != 0 || bvalid) && n < 300) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 300) fail_evt("drain_timeout");
        @(posedge aclk); #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({awready, wready, bvalid, mem_we, bid, bresp, outstanding_count}), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        chk({tag, "_mem_wstrb"}, 64'(mem_wstrb), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aw_t         a;
        aw_t         dropped;
        logic [63:0] d;
        bit          saw_b;
        int          bl;

        repeat (3) @(negedge aclk);
        check_outputs_zero("reset");
        #1 aresetn = 1'b1;
        chk("awready_at_release", 64'(awready), 64'd0);
        @(negedge aclk);
        chk("awready_after_release", 64'(awready), 64'd1);
        @(posedge aclk); #1;

        // INCR plus first-beat latency
        send_aw('{4'd5, 32'h100, 8'd3, 3'd3, 2'b01});
        @(negedge aclk);
        chk("wready_n1", 64'(wready), 64'd0);
        @(negedge aclk);
        chk("wready_n2", 64'(wready), 64'd1);
        @(posedge aclk); #1;
        send_w(-1);
        drain();

        run('{4'd1, 32'h118, 8'd3, 3'd3, 2'b10}, -1);
        run('{4'd2, 32'h118, 8'd2, 3'd3, 2'b10}, -1);
        strb_plan.push_back(8'hF0);
        strb_plan.push_back(8'h0F);
        strb_plan.push_back(8'hFF);
        run('{4'd3, 32'h40, 8'd2, 3'd2, 2'b00}, -1);
        run('{4'd4, 32'h3000, 8'd1, 3'd3, 2'b01}, -1);
        drain();

        // Outstanding: first AW goes straight to the FSM, the next 16 fill the FIFO
        for (int i = 0; i < 17; i++) send_aw('{4'(i), 32'h1000 + 32'(i * 8), 8'd0, 3'd3, 2'b01});
        @(negedge aclk);
        chk("count_full", 64'(outstanding_count), 64'd16);
        chk("awready_full", 64'(awready), 64'd0);
        @(posedge aclk); #1;
        fork
            send_aw('{4'd1, 32'h2000, 8'd0, 3'd3, 2'b01});
            for (int i = 0; i < 18; i++) send_w(-1);
        join
        chk("blocked_aw_prev_count", 64'(prev_count), 64'd16);
        chk("blocked_aw_acc_count", 64'(acc_count), 64'd15);
        drain();

        run('{4'd3, 32'h300, 8'd3, 3'd3, 2'b01}, 1);
        drain();

        bready = 1'b0;
        run('{4'd9, 32'h400, 8'd1, 3'd3, 2'b01}, -1);
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            chk("stall_b", 64'({bvalid, bid, bresp}), 64'({1'b1, 4'd9, 2'b00}));
        end
        @(posedge aclk); #1;
        bready = 1'b1;
        drain();

        // Reset while the third beat of a 4-beat INCR is on the bus
        a = '{4'd7, 32'h500, 8'd3, 3'd3, 2'b01};
        send_aw(a);
        dropped = pend.pop_front();
        for (int i = 0; i < 2; i++) begin
            d = {$urandom, $urandom};
            exp_w.push_back('{model_addr(dropped, i), d, 8'hFF});
            drive_beat(d, 8'hFF, 1'b0);
        end
        wdata = {$urandom, $urandom}; wstrb = 8'hFF; wvalid = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        check_outputs_zero("midburst_reset");
        wvalid = 1'b0;
        repeat (2) @(negedge aclk);
        #1 aresetn = 1'b1;
        chk("awready_at_release2", 64'(awready), 64'd0);
        @(negedge aclk);
        chk("awready_after_release2", 64'(awready), 64'd1);
        saw_b = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            if (bvalid) saw_b = 1;
        end
        chk("no_b_after_reset", 64'(saw_b), 64'd0);
        @(posedge aclk); #1;

        for (int t = 0; t < 40; t++) begin
            a.id    = 4'($urandom);
            a.burst = 2'($urandom_range(0, 3));
            a.size  = 3'($urandom_range(0, 4));
            if (a.burst == 2'b10 && $urandom_range(0, 4) != 0) begin
                case ($urandom_range(0, 3))
                    0:       a.len = 8'd1;
                    1:       a.len = 8'd3;
                    2:       a.len = 8'd7;
                    default: a.len = 8'd15;
                endcase
            end else begin
                a.len = 8'($urandom_range(0, 15));
            end
            a.addr = $urandom_range(0, 32'h37FF);
            if ($urandom_range(0, 3) != 0) a.addr = a.addr & ~((32'd1 << a.size) - 32'd1);
            bl = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, int'(a.len))) : -1;
            run(a, bl);
        end
        drain();

        chk("exp_w_empty", 64'(exp_w.size()), 64'd0);
        chk("exp_b_empty", 64'(exp_b.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
